// File: rtl/custom_apb_lcd_fifo.sv
// rtl/custom_apb_lcd_fifo.sv - APB3 slave that queues LCD command/data words and replays
// them on an 8080-style write bus with programmable WR low/high timing.
module custom_apb_lcd_fifo #(
  parameter int ADDRWIDTH  = 12,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic [ADDRWIDTH-1:0]  PADDR,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [31:0]           PWDATA,
  input  logic [3:0]            ECOREVNUM,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  LCD_CS,
  output logic                  LCD_RS,
  output logic                  LCD_WR,
  output logic                  LCD_RD,
  output logic                  LCD_RST,
  output logic                  LCD_BL_CTR,
  output logic [DATA_WIDTH-1:0] LCD_DATA
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int EW  = DATA_WIDTH + 1;
  localparam int WAW = ADDRWIDTH - 2;

  localparam logic [WAW-1:0] A_CTRL   = WAW'(0);
  localparam logic [WAW-1:0] A_TIMING = WAW'(1);
  localparam logic [WAW-1:0] A_CMD    = WAW'(2);
  localparam logic [WAW-1:0] A_DATA   = WAW'(3);
  localparam logic [WAW-1:0] A_STATUS = WAW'(4);
  localparam logic [WAW-1:0] A_ID     = WAW'(5);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  cs_q, cs_d;
  logic                  rs_q, rs_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  en_q, en_d;
  logic                  rst_q, rst_d;
  logic                  bl_q, bl_d;
  logic                  flush_q, flush_d;
  logic [CNT_WIDTH-1:0]  low_q, low_d;
  logic [CNT_WIDTH-1:0]  high_q, high_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];

  logic [WAW-1:0] word_addr;
  logic           apb_wr_phase;
  logic           is_push_addr;
  logic           full;
  logic           empty;
  logic           avail;
  logic           wr_en;
  logic           push;
  logic           pop;
  logic [EW-1:0]  push_entry;
  logic [EW-1:0]  head;
  logic           unused_bits;

  assign word_addr    = PADDR[ADDRWIDTH-1:2];
  assign apb_wr_phase = PSEL & PENABLE & PWRITE;
  assign is_push_addr = (word_addr == A_CMD) | (word_addr == A_DATA);
  assign full         = (level_q == LW'(FIFO_DEPTH));
  assign empty        = (level_q == '0);
  // A pending flush hides the FIFO contents so neither the FSM nor a push can slip past it.
  assign avail        = ~empty & ~flush_q;
  assign PREADY       = ~(apb_wr_phase & is_push_addr & full);
  assign wr_en        = apb_wr_phase & PREADY;
  assign push         = wr_en & is_push_addr & ~flush_q;
  assign push_entry   = {word_addr == A_DATA, PWDATA[DATA_WIDTH-1:0]};
  assign head         = mem_q[rptr_q];
  assign unused_bits  = ^{PADDR[1:0], PWDATA};

  assign PSLVERR    = 1'b0;
  assign LCD_RD     = 1'b1;
  assign LCD_CS     = cs_q;
  assign LCD_RS     = rs_q;
  assign LCD_WR     = wr_q;
  assign LCD_DATA   = data_q;
  assign LCD_RST    = rst_q;
  assign LCD_BL_CTR = bl_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    wr_d    = wr_q;
    rs_d    = rs_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_q & avail) begin
          pop     = 1'b1;
          rs_d    = head[EW-1];
          data_d  = head[DATA_WIDTH-1:0];
          cs_d    = 1'b0;
          wr_d    = 1'b0;
          cnt_d   = low_q;
          state_d = S_LOW;
        end else begin
          cs_d = 1'b1;
          wr_d = 1'b1;
        end
      end
      S_LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end else begin
          wr_d    = 1'b1;
          cnt_d   = high_q;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end else if (en_q & avail) begin
          // Back-to-back burst: CS stays low and the next word goes straight to LOW.
          pop     = 1'b1;
          rs_d    = head[EW-1];
          data_d  = head[DATA_WIDTH-1:0];
          wr_d    = 1'b0;
          cnt_d   = low_q;
          state_d = S_LOW;
        end else begin
          cs_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    en_d    = en_q;
    rst_d   = rst_q;
    bl_d    = bl_q;
    flush_d = 1'b0;
    low_d   = low_q;
    high_d  = high_q;
    if (wr_en && word_addr == A_CTRL) begin
      en_d    = PWDATA[0];
      rst_d   = PWDATA[1];
      bl_d    = PWDATA[2];
      flush_d = PWDATA[3];
    end
    if (wr_en && word_addr == A_TIMING) begin
      low_d  = PWDATA[CNT_WIDTH-1:0];
      high_d = PWDATA[16+CNT_WIDTH-1:16];
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_q) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL & ~PWRITE) begin
      case (word_addr)
        A_CTRL:   PRDATA = {29'b0, bl_q, rst_q, en_q};
        A_TIMING: PRDATA = 32'(low_q) | (32'(high_q) << 16);
        A_STATUS: PRDATA = {16'b0, 8'(level_q), 5'b0, full, empty, state_q != S_IDLE};
        A_ID:     PRDATA = 32'h4C43_4410 | {28'b0, ECOREVNUM};
        default:  PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cs_q    <= 1'b1;
      rs_q    <= 1'b1;
      wr_q    <= 1'b1;
      data_q  <= '0;
      en_q    <= 1'b0;
      rst_q   <= 1'b0;
      bl_q    <= 1'b0;
      flush_q <= 1'b0;
      low_q   <= CNT_WIDTH'(1);
      high_q  <= CNT_WIDTH'(1);
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      rs_q    <= rs_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      rst_q   <= rst_d;
      bl_q    <= bl_d;
      flush_q <= flush_d;
      low_q   <= low_d;
      high_q  <= high_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) mem_q[wptr_q] <= push_entry;
  end

endmodule

// File: tb/tb_custom_apb_lcd_fifo.sv
// tb/tb_custom_apb_lcd_fifo.sv - directed and randomized bench for custom_apb_lcd_fifo,
// checking captured LCD words and WR/CS timing against a queue-based reference.
module tb_custom_apb_lcd_fifo;

  localparam logic [11:0] A_CTRL   = 12'h000;
  localparam logic [11:0] A_TIMING = 12'h004;
  localparam logic [11:0] A_CMD    = 12'h008;
  localparam logic [11:0] A_DATA   = 12'h00C;
  localparam logic [11:0] A_STATUS = 12'h010;
  localparam logic [11:0] A_ID     = 12'h014;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0;
  logic [11:0] PADDR = '0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  ECOREVNUM = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_BL_CTR;
  logic [15:0] LCD_DATA;

  custom_apb_lcd_fifo dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .ECOREVNUM(ECOREVNUM), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .LCD_CS(LCD_CS), .LCD_RS(LCD_RS),
    .LCD_WR(LCD_WR), .LCD_RD(LCD_RD), .LCD_RST(LCD_RST), .LCD_BL_CTR(LCD_BL_CTR),
    .LCD_DATA(LCD_DATA)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad = 0;

  // Panel-side observation: words latched at WR rise, plus phase and CS-low run lengths.
  logic [16:0] cap_l[$];
  logic [16:0] exp_l[$];
  int          low_l[$];
  int          high_l[$];
  int          cs_l[$];
  int          low_run = 0;
  int          high_run = 0;
  int          cs_run = 0;
  logic        prev_wr = 1'b1;

  always @(negedge PCLK) begin
    if (PRESET) begin
      low_run = 0; high_run = 0; cs_run = 0; prev_wr = 1'b1;
    end else begin
      if (!LCD_WR) low_run++;
      else if (!prev_wr) begin
        cap_l.push_back({LCD_RS, LCD_DATA});
        low_l.push_back(low_run);
        low_run = 0;
      end
      if (LCD_WR && !LCD_CS) high_run++;
      else if (high_run != 0) begin
        high_l.push_back(high_run);
        high_run = 0;
      end
      if (!LCD_CS) cs_run++;
      else if (cs_run != 0) begin
        cs_l.push_back(cs_run);
        cs_run = 0;
      end
      prev_wr = LCD_WR;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_mon();
    cap_l.delete(); exp_l.delete(); low_l.delete(); high_l.delete(); cs_l.delete();
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output int stalls);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    stalls = 0;
    #1;
    while (PREADY !== 1'b1 && stalls < 200) begin
      @(negedge PCLK); #1;
      stalls++;
    end
    check("apb_write_bound", stalls < 200, 1'b1);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int c = 0;
    while (cap_l.size() < n && c < 2000) begin
      @(negedge PCLK);
      c++;
    end
    check("word_count", cap_l.size(), n);
    repeat (12) @(negedge PCLK);
  endtask

  task automatic push_word(input logic rs, input logic [15:0] d);
    int st;
    apb_write(rs ? A_DATA : A_CMD, {16'h0, d}, st);
    exp_l.push_back({rs, d});
  endtask

  initial begin
    logic [31:0] rd;
    int st, st9, k, lo, hi, n;
    logic [15:0] d;
    logic rs;

    ECOREVNUM = 4'($urandom_range(0, 15));
    repeat (3) @(negedge PCLK);
    check("rst_cs", LCD_CS, 1'b1);
    check("rst_wr", LCD_WR, 1'b1);
    check("rst_rd", LCD_RD, 1'b1);
    check("rst_rs", LCD_RS, 1'b1);
    check("rst_lcdrst", LCD_RST, 1'b0);
    check("rst_bl", LCD_BL_CTR, 1'b0);
    check("rst_data", LCD_DATA, 16'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pready", PREADY, 1'b1);
    check("pslverr", PSLVERR, 1'b0);
    PRESET = 1'b0;
    apb_read(A_STATUS, rd); check("rst_status", rd, 32'h0000_0002);
    apb_read(A_ID, rd);     check("id", rd, 32'h4C43_4410 | {28'h0, ECOREVNUM});
    apb_read(A_TIMING, rd); check("rst_timing", rd, 32'h0001_0001);
    apb_read(A_CTRL, rd);   check("rst_ctrl", rd, 32'h0);
    apb_read(12'h018, rd);  check("unmapped_rd", rd, 32'h0);
    apb_write(A_STATUS, 32'hFFFF_FFFF, st);
    apb_read(A_STATUS, rd); check("ro_status", rd, 32'h0000_0002);

    // Two-word transfer at fastest timing
    clear_mon();
    apb_write(A_TIMING, 32'h0, st);
    apb_write(A_CTRL, 32'h1, st);
    push_word(1'b0, 16'h002C);
    push_word(1'b1, 16'hF800);
    wait_words(2);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t2_word%0d", i), cap_l[i], exp_l[i]);
      check($sformatf("t2_low%0d", i), low_l[i], 1);
      check($sformatf("t2_high%0d", i), high_l[i], 1);
    end
    check("t2_cs_idle", LCD_CS, 1'b1);
    apb_read(A_STATUS, rd); check("t2_status", rd, 32'h0000_0002);

    // Single word with stretched phases: CS low spans exactly the busy period
    clear_mon();
    apb_write(A_TIMING, (32'd3 << 16) | 32'd2, st);
    push_word(1'b1, 16'h1234);
    wait_words(1);
    check("t3_word", cap_l[0], exp_l[0]);
    check("t3_low", low_l[0], 3);
    check("t3_high", high_l[0], 4);
    check("t3_cs_runs", cs_l.size(), 1);
    check("t3_busy_len", cs_l[0], 7);

    // Fill the FIFO with EN=0, then stall a ninth push until a pop
    apb_write(A_CTRL, 32'h0, st);
    apb_write(A_TIMING, 32'h0, st);
    clear_mon();
    for (int i = 0; i < 8; i++) push_word(1'($urandom), 16'($urandom));
    apb_read(A_STATUS, rd); check("t4_full_status", rd, 32'h0000_0804);
    check("t4_held", cap_l.size(), 0);
    d = 16'($urandom); rs = 1'($urandom);
    fork
      apb_write(rs ? A_DATA : A_CMD, {16'h0, d}, st9);
      begin
        repeat (4) @(negedge PCLK);
        #2 check("t4_pready_low", PREADY, 1'b0);
        force dut.en_q = 1'b1;
      end
    join
    exp_l.push_back({rs, d});
    check("t4_stalled", st9 > 0, 1'b1);
    apb_write(A_CTRL, 32'h1, st);
    release dut.en_q;
    wait_words(9);
    for (int i = 0; i < 9; i++) check($sformatf("t4_word%0d", i), cap_l[i], exp_l[i]);
    apb_read(A_STATUS, rd); check("t4_drained", rd, 32'h0000_0002);

    // Randomized bursts: whole queue loaded with EN=0 so it plays out as one CS-low burst
    for (int r = 0; r < 4; r++) begin
      apb_write(A_CTRL, 32'h0, st);
      lo = $urandom_range(0, 3); hi = $urandom_range(0, 3); n = $urandom_range(1, 8);
      apb_write(A_TIMING, (32'(hi) << 16) | 32'(lo), st);
      clear_mon();
      for (int i = 0; i < n; i++) push_word(1'($urandom), 16'($urandom));
      apb_write(A_CTRL, 32'h1, st);
      wait_words(n);
      for (int i = 0; i < n; i++) begin
        check($sformatf("rnd%0d_word%0d", r, i), cap_l[i], exp_l[i]);
        check($sformatf("rnd%0d_low%0d", r, i), low_l[i], lo + 1);
        check($sformatf("rnd%0d_high%0d", r, i), high_l[i], hi + 1);
      end
      check($sformatf("rnd%0d_cs_runs", r), cs_l.size(), 1);
      check($sformatf("rnd%0d_burst_len", r), cs_l[0], n * (lo + hi + 2));
    end

    // EN cleared mid-burst, then FLUSH together with EN
    apb_write(A_CTRL, 32'h0, st);
    apb_write(A_TIMING, (32'd2 << 16) | 32'd2, st);
    clear_mon();
    for (int i = 0; i < 6; i++) push_word(1'($urandom), 16'($urandom));
    apb_write(A_CTRL, 32'h1, st);
    apb_write(A_CTRL, 32'h0, st);
    k = 0;
    while (LCD_CS !== 1'b1 && k < 100) begin
      @(negedge PCLK);
      k++;
    end
    check("t5_cs_release", LCD_CS, 1'b1);
    repeat (10) @(negedge PCLK);
    k = cap_l.size();
    check("t5_partial", (k >= 1) && (k < 6), 1'b1);
    for (int i = 0; i < k; i++) begin
      check($sformatf("t5_word%0d", i), cap_l[i], exp_l[i]);
      check($sformatf("t5_low%0d", i), low_l[i], 3);
    end
    apb_read(A_STATUS, rd); check("t5_retained", rd, 32'(6 - k) << 8);
    apb_write(A_CTRL, 32'h9, st);
    apb_read(A_CTRL, rd);   check("t5_flush_reads0", rd, 32'h1);
    apb_read(A_STATUS, rd); check("t5_flushed", rd, 32'h0000_0002);
    repeat (30) @(negedge PCLK);
    check("t5_no_more_words", cap_l.size(), k);
    check("t5_cs_high", LCD_CS, 1'b1);

    // Reset asserted during a LOW phase
    apb_write(A_CTRL, 32'h0, st);
    apb_write(A_TIMING, (32'd1 << 16) | 32'd5, st);
    for (int i = 0; i < 3; i++) push_word(1'b1, 16'($urandom));
    apb_write(A_CTRL, 32'h7, st);
    check("t6_rst_pin", LCD_RST, 1'b1);
    check("t6_bl_pin", LCD_BL_CTR, 1'b1);
    k = 0;
    while (LCD_WR !== 1'b0 && k < 50) begin
      @(negedge PCLK);
      k++;
    end
    check("t6_in_low", LCD_WR, 1'b0);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("t6_cs", LCD_CS, 1'b1);
    check("t6_wr", LCD_WR, 1'b1);
    check("t6_rs", LCD_RS, 1'b1);
    check("t6_rd", LCD_RD, 1'b1);
    check("t6_lcdrst", LCD_RST, 1'b0);
    check("t6_bl", LCD_BL_CTR, 1'b0);
    check("t6_data", LCD_DATA, 16'h0);
    PRESET = 1'b0;
    apb_read(A_STATUS, rd); check("t6_status", rd, 32'h0000_0002);
    apb_read(A_TIMING, rd); check("t6_timing", rd, 32'h0001_0001);
    apb_read(A_CTRL, rd);   check("t6_ctrl", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
